// File: rtl/avr_adc_spi_master.sv
// AVR ADC SPI master: ships each 10-bit ADC sample plus its 4-bit channel tag
// as a 16-bit SPI mode-0 frame (byte0 = sample[7:0], byte1 = {chan, 2'b00,
// sample[9:8]}), captures the slave's reply bytes on MISO and tracks the
// channel the slave wants converted next.
module avr_adc_spi_master #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned SS_GAP  = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [9:0] sample_i,
   input  logic [3:0] sample_channel_i,
   input  logic       new_sample_i,
   output logic       busy_o,
   output logic       spi_ss_o,
   output logic       spi_sck_o,
   output logic       spi_mosi_o,
   input  logic       spi_miso_i,
   input  logic [3:0] spi_channel_i,
   output logic [3:0] next_channel_o,
   output logic [7:0] miso_data_o,
   output logic       frame_done_o
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD,
      GAP
   } state_e;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(SS_GAP - 1);

   state_e      state_q;
   logic [7:0]  cnt_q;
   logic [3:0]  bitIdx_q;
   logic [15:0] txShift_q;
   logic [7:0]  rxShift_q;
   logic [7:0]  rxShift_d;
   logic        busy_q;
   logic        ss_q;
   logic        sck_q;
   logic        mosi_q;
   logic [3:0]  nextChannel_q;
   logic [7:0]  misoData_q;
   logic        frameDone_q;

   // Receive shifter input: the MISO bit that would be captured on this edge.
   assign rxShift_d = {rxShift_q[6:0], spi_miso_i};

   // Frame sequencer: every SPI pin and status flag is a register so that no
   // input can reach the bus combinationally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         bitIdx_q      <= 4'd0;
         txShift_q     <= 16'd0;
         rxShift_q     <= 8'd0;
         busy_q        <= 1'b0;
         ss_q          <= 1'b1;
         sck_q         <= 1'b0;
         mosi_q        <= 1'b0;
         nextChannel_q <= 4'h0;
         misoData_q    <= 8'h00;
         frameDone_q   <= 1'b0;
      end else begin
         frameDone_q <= 1'b0;
         if (ss_q) begin
            nextChannel_q <= spi_channel_i;
         end
         case (state_q)
            IDLE: begin
               if (new_sample_i) begin
                  txShift_q <= {sample_i[7:0], sample_channel_i, 2'b00, sample_i[9:8]};
                  mosi_q    <= sample_i[7];
                  ss_q      <= 1'b0;
                  sck_q     <= 1'b0;
                  busy_q    <= 1'b1;
                  cnt_q     <= 8'd0;
                  bitIdx_q  <= 4'd0;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_q <= 8'd0;
                  if (!sck_q) begin
                     sck_q     <= 1'b1;
                     rxShift_q <= rxShift_d;
                     if (bitIdx_q[2:0] == 3'd7) begin
                        misoData_q <= rxShift_d;
                     end
                  end else begin
                     sck_q <= 1'b0;
                     if (bitIdx_q == 4'd15) begin
                        mosi_q  <= 1'b0;
                        state_q <= HOLD;
                     end else begin
                        bitIdx_q  <= bitIdx_q + 4'd1;
                        txShift_q <= {txShift_q[14:0], 1'b0};
                        mosi_q    <= txShift_q[14];
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            HOLD: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_q       <= 8'd0;
                  ss_q        <= 1'b1;
                  frameDone_q <= 1'b1;
                  state_q     <= GAP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q   <= 8'd0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o         = busy_q;
   assign spi_ss_o       = ss_q;
   assign spi_sck_o      = sck_q;
   assign spi_mosi_o     = mosi_q;
   assign next_channel_o = nextChannel_q;
   assign miso_data_o    = misoData_q;
   assign frame_done_o   = frameDone_q;

endmodule

// File: tb/tb_avr_adc_spi_master.sv
// Bench for avr_adc_spi_master: randomized requests, a behavioural timing
// model for busy / slave select / next_channel, a slave that answers on MISO,
// and a monitor that reassembles each frame and checks it against a queue of
// expected frames.
module tb_avr_adc_spi_master;

   localparam int D = 4;
   localparam int G = 2;
   localparam int SS_LOW = 33 * D;
   localparam int PERIOD = 33 * D + G + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] sample = 10'd0;
   logic [3:0] sampleChannel = 4'd0;
   logic       newSample = 1'b0;
   logic       spiMiso = 1'b0;
   logic [3:0] spiChannel = 4'd0;
   logic       busy;
   logic       spiSs;
   logic       spiSck;
   logic       spiMosi;
   logic [3:0] nextChannel;
   logic [7:0] misoData;
   logic       frameDone;

   int checks = 0;
   int failures = 0;

   int edgeCnt = 0;
   int acceptEdge = 0;
   int nextAllowed = 0;
   bit hasFrame = 1'b0;
   logic [3:0] nextChanExp = 4'h0;
   int acceptCount = 0;
   int abandoned = 0;
   int frameDoneSeen = 0;
   int misoMode = 0;

   logic [15:0] expQ[$];
   logic [15:0] misoExpQ[$];

   avr_adc_spi_master #(
      .CLK_DIV(D),
      .SS_GAP (G)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .sample_i        (sample),
      .sample_channel_i(sampleChannel),
      .new_sample_i    (newSample),
      .busy_o          (busy),
      .spi_ss_o        (spiSs),
      .spi_sck_o       (spiSck),
      .spi_mosi_o      (spiMosi),
      .spi_miso_i      (spiMiso),
      .spi_channel_i   (spiChannel),
      .next_channel_o  (nextChannel),
      .miso_data_o     (misoData),
      .frame_done_o    (frameDone)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Count rising edges so the timing model can talk in cycle numbers.
   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   task automatic checkVal(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Slave select is low for SS_LOW cycles starting after the accepting edge.
   function automatic bit ssLowExp(input int n);
      return hasFrame && (n >= acceptEdge) && (n < acceptEdge + SS_LOW);
   endfunction

   // Compare the cycle-level status outputs against the timing model.
   task automatic checkOutput();
      int n;
      n = edgeCnt;
      checkVal("busy", busy, int'(n + 1 < nextAllowed));
      checkVal("spi_ss", spiSs, int'(!ssLowExp(n)));
      checkVal("next_channel", nextChannel, nextChanExp);
      if (!ssLowExp(n)) checkVal("sck_idle", spiSck, 0);
   endtask

   // Drive one cycle of inputs and advance the model for the coming edge.
   task automatic driveInputs(input bit ns, input logic [9:0] s, input logic [3:0] ch,
                              input logic [3:0] sc);
      int n;
      int si;
      int ci;
      n = edgeCnt;
      newSample     = ns;
      sample        = s;
      sampleChannel = ch;
      spiChannel    = sc;
      if (!ssLowExp(n)) nextChanExp = sc;
      if (ns && (n + 1 >= nextAllowed)) begin
         si = int'(s);
         ci = int'(ch);
         acceptEdge  = n + 1;
         hasFrame    = 1'b1;
         nextAllowed = n + 1 + PERIOD;
         acceptCount++;
         expQ.push_back(16'((si % 256) * 256 + ci * 16 + si / 256));
      end
   endtask

   task automatic applyStimulus(input bit ns, input logic [9:0] s, input logic [3:0] ch,
                                input logic [3:0] sc);
      @(negedge clk);
      checkOutput();
      driveInputs(ns, s, ch, sc);
   endtask

   task automatic idleCycles(input int k, input logic [3:0] sc);
      for (int i = 0; i < k; i++) applyStimulus(1'b0, 10'($urandom), 4'($urandom), sc);
   endtask

   task automatic checkResetValues();
      checkVal("rst_ss", spiSs, 1);
      checkVal("rst_sck", spiSck, 0);
      checkVal("rst_mosi", spiMosi, 0);
      checkVal("rst_busy", busy, 0);
      checkVal("rst_frame_done", frameDone, 0);
      checkVal("rst_miso_data", misoData, 0);
      checkVal("rst_next_channel", nextChannel, 0);
   endtask

   // Asynchronous reset between clock edges, then a request on the first edge.
   task automatic doReset(input int holdCycles);
      @(negedge clk);
      checkOutput();
      #2;
      rst_n = 1'b0;
      newSample = 1'b0;
      #1;
      checkResetValues();
      abandoned += expQ.size();
      expQ.delete();
      hasFrame    = 1'b0;
      nextAllowed = 0;
      nextChanExp = 4'h0;
      repeat (holdCycles) @(negedge clk);
      rst_n = 1'b1;
      driveInputs(1'b1, 10'($urandom), 4'($urandom), spiChannel);
   endtask

   // Slave model: picks a reply word per frame and presents each bit while SCK is low.
   logic [15:0] misoWord = 16'd0;
   int slvRise = 0;
   bit slvActive = 1'b0;
   logic slvPrevSck = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         slvActive  = 1'b0;
         slvRise    = 0;
         slvPrevSck = 1'b0;
         misoExpQ.delete();
         spiMiso = 1'b0;
      end else begin
         if (!spiSs && !slvActive) begin
            slvActive = 1'b1;
            slvRise   = 0;
            misoWord  = (misoMode != 0) ? 16'hFFFF : 16'($urandom);
            misoExpQ.push_back(misoWord);
         end
         if (slvActive && spiSck && !slvPrevSck) slvRise++;
         slvPrevSck = spiSck;
         if (spiSs) slvActive = 1'b0;
         if (slvActive && !spiSck && slvRise < 16) spiMiso = misoWord[4'(15 - slvRise)];
      end
   end

   // Monitor: rebuilds each frame from the bus and scores it on frame_done.
   int monLow = 0;
   int monPulses = 0;
   int monViol = 0;
   logic [15:0] monBits = 16'd0;
   logic monPrevSck = 1'b0;
   logic monPrevMosi = 1'b0;
   logic monPrevFd = 1'b0;
   always @(negedge clk) begin
      logic [15:0] mw;
      if (!rst_n) begin
         monLow      = 0;
         monPulses   = 0;
         monViol     = 0;
         monBits     = 16'd0;
         monPrevSck  = 1'b0;
         monPrevMosi = 1'b0;
         monPrevFd   = 1'b0;
      end else begin
         if (!spiSs) begin
            monLow++;
            if (spiSck && !monPrevSck) begin
               monBits = {monBits[14:0], spiMosi};
               monPulses++;
               if (monPulses == 8 || monPulses == 16) begin
                  checkVal("miso_reply_queued", int'(misoExpQ.size() > 0), 1);
                  if (misoExpQ.size() > 0) begin
                     mw = misoExpQ[0];
                     if (monPulses == 8) checkVal("miso_byte0", misoData, int'(mw) / 256);
                     else checkVal("miso_byte1", misoData, int'(mw) % 256);
                  end
               end
            end
            if (spiSck && monPrevSck && (spiMosi != monPrevMosi)) monViol++;
         end
         if (frameDone) begin
            frameDoneSeen++;
            checkVal("frame_done_width", monPrevFd, 0);
            checkVal("ss_high_at_done", spiSs, 1);
            checkVal("sck_pulses", monPulses, 16);
            checkVal("ss_low_cycles", monLow, SS_LOW);
            checkVal("mosi_stable_high", monViol, 0);
            checkVal("frame_expected", int'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
               mw = expQ.pop_front();
               checkVal("mosi_word", monBits, mw);
            end
            if (misoExpQ.size() > 0) void'(misoExpQ.pop_front());
            monLow    = 0;
            monPulses = 0;
            monViol   = 0;
            monBits   = 16'd0;
         end
         monPrevSck  = spiSck;
         monPrevMosi = spiMosi;
         monPrevFd   = frameDone;
      end
   end

   // Main stimulus sequence.
   initial begin
      repeat (2) @(negedge clk);
      #1;
      checkResetValues();
      @(negedge clk);
      rst_n = 1'b1;
      driveInputs(1'b0, 10'd0, 4'd0, 4'd0);

      // Directed frame: bytes A5 then 32.
      applyStimulus(1'b1, 10'h2A5, 4'h3, 4'h0);
      idleCycles(PERIOD + 5, 4'h0);

      // Slave answers all ones.
      misoMode = 1;
      applyStimulus(1'b1, 10'($urandom), 4'($urandom), 4'h0);
      idleCycles(PERIOD + 3, 4'h0);
      misoMode = 0;

      // Request while busy must be ignored.
      applyStimulus(1'b1, 10'h155, 4'hA, 4'h0);
      idleCycles(60, 4'h0);
      applyStimulus(1'b1, 10'h3FF, 4'hF, 4'h0);
      idleCycles(PERIOD, 4'h0);

      // Slave channel changes while SS is low.
      applyStimulus(1'b1, 10'($urandom), 4'($urandom), 4'h1);
      idleCycles(40, 4'h1);
      idleCycles(PERIOD, 4'h7);

      // Continuous requests: back-to-back frames.
      for (int i = 0; i < 3 * PERIOD + 10; i++)
         applyStimulus(1'b1, 10'($urandom), 4'($urandom), 4'($urandom));
      idleCycles(PERIOD, 4'h2);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         logic [3:0] sc;
         sc = ($urandom_range(0, 7) == 0) ? 4'($urandom) : spiChannel;
         applyStimulus($urandom_range(0, 19) == 0, 10'($urandom), 4'($urandom), sc);
      end
      idleCycles(PERIOD, 4'h5);

      // Reset in the middle of byte0 (after bit 5), then a fresh frame.
      applyStimulus(1'b1, 10'h0F3, 4'h9, 4'h5);
      idleCycles(50, 4'h5);
      doReset(2);
      idleCycles(2 * PERIOD, 4'h6);

      checkVal("pending_frames", expQ.size(), 0);
      checkVal("frame_count", frameDoneSeen, acceptCount - abandoned);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
